// File: rtl/req_encoder.sv
// req_encoder: registered 8-to-3 priority encoder with request latching and a
// valid/ack handshake toward a downstream decoder.
//
// Rising edges on req are latched into a pending vector. When idle, the
// priority index of the pending vector is registered onto vector2..0 and
// offered with valid. The code stays frozen until ack, which clears that
// pending bit.
//
// Parameters:
//   LOW_WINS  0 = highest index wins (req[7] first), 1 = lowest index wins
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   8 request lines, a rising edge raises a request
//   ack      in   consumer accepts the presented code (only while valid=1)
//   vector2  out  code bit 2 (MSB) of the presented index
//   vector1  out  code bit 1
//   vector0  out  code bit 0 (LSB)
//   valid    out  code is stable and must be consumed
//   pending  out  latched requests not yet acknowledged (incl. presented one)
//   lost     out  one-cycle pulse: an edge hit a bit that was already pending
module req_encoder #(
    parameter bit LOW_WINS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
    output logic       vector2,
    output logic       vector1,
    output logic       vector0,
    output logic       valid,
    output logic [7:0] pending,
    output logic       lost
);

    typedef enum logic [0:0] {
        StIdle,
        StPresent
    } state_e;

    state_e     state_q;
    logic [7:0] req_q;
    logic [7:0] pending_q;
    logic [2:0] code_q;
    logic       valid_q;
    logic       lost_q;

    logic [7:0] new_req;
    logic [7:0] clr;
    logic       accept;
    logic [2:0] pick;

    // Priority index of the registered pending vector; the last match in the
    // scan order is the winner.
    always_comb begin
        pick = 3'd0;
        if (LOW_WINS) begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) pick = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) pick = 3'(i);
            end
        end
    end

    always_comb begin
        new_req = req & ~req_q;
        accept  = (state_q == StPresent) && ack;
        clr     = accept ? (8'd1 << code_q) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_q     <= 8'd0;
            pending_q <= 8'd0;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            req_q     <= req;
            // Clear is applied before the OR so a same-cycle edge keeps the bit set.
            pending_q <= (pending_q & ~clr) | new_req;
            lost_q    <= |(new_req & pending_q & ~clr);
            unique case (state_q)
                StIdle: begin
                    if (pending_q != 8'd0) begin
                        code_q  <= pick;
                        valid_q <= 1'b1;
                        state_q <= StPresent;
                    end
                end
                StPresent: begin
                    // Code is frozen here; only ack moves us on.
                    if (ack) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vector2 = code_q[2];
    assign vector1 = code_q[1];
    assign vector0 = code_q[0];
    assign valid   = valid_q;
    assign pending = pending_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: two instances (highest-wins and lowest-wins) share
// stimulus; a set-based handshake model predicts every output each cycle, and
// literal checks pin the directed scenarios.
module tb_req_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       ack;

    logic [1:0][2:0] d_vec;
    logic [1:0]      d_valid;
    logic [1:0][7:0] d_pend;
    logic [1:0]      d_lost;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    req_encoder #(.LOW_WINS(1'b0)) u_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .vector2 (d_vec[0][2]),
        .vector1 (d_vec[0][1]),
        .vector0 (d_vec[0][0]),
        .valid   (d_valid[0]),
        .pending (d_pend[0]),
        .lost    (d_lost[0])
    );

    req_encoder #(.LOW_WINS(1'b1)) u_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .vector2 (d_vec[1][2]),
        .vector1 (d_vec[1][1]),
        .vector0 (d_vec[1][0]),
        .valid   (d_valid[1]),
        .pending (d_pend[1]),
        .lost    (d_lost[1])
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Index chosen from a set of requests under a given priority direction.
    function automatic int choose(input logic [7:0] p, input bit low);
        for (int j = 0; j < 8; j++) begin
            int k;
            k = low ? j : 7 - j;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    // Model: set of outstanding requests, index currently offered (-1 none),
    // last offered index (what the code lines show), and the lost flag.
    logic [7:0] m_pend [2];
    int         m_shown [2];
    int         m_last [2];
    logic       m_lost [2];
    logic [7:0] m_seen;
    logic [7:0] edges;
    logic [7:0] gone;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_seen = 8'd0;
            for (int m = 0; m < 2; m++) begin
                m_pend[m]  = 8'd0;
                m_shown[m] = -1;
                m_last[m]  = 0;
                m_lost[m]  = 1'b0;
            end
        end else begin
            edges = req & ~m_seen;
            for (int m = 0; m < 2; m++) begin
                gone = (m_shown[m] >= 0 && ack) ? (8'd1 << m_shown[m]) : 8'd0;
                m_lost[m] = |(edges & m_pend[m] & ~gone);
                if (m_shown[m] >= 0) begin
                    if (ack) m_shown[m] = -1;
                end else if (m_pend[m] != 8'd0) begin
                    m_shown[m] = choose(m_pend[m], m == 1);
                    m_last[m]  = m_shown[m];
                end
                m_pend[m] = (m_pend[m] & ~gone) | edges;
            end
            m_seen = req;
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            check($sformatf("model[%0d].valid", m), 8'(d_valid[m]), 8'(m_shown[m] >= 0));
            check($sformatf("model[%0d].vector", m), 8'(d_vec[m]), 8'(m_last[m]));
            check($sformatf("model[%0d].pending", m), d_pend[m], m_pend[m]);
            check($sformatf("model[%0d].lost", m), 8'(d_lost[m]), 8'(m_lost[m]));
        end
    end

    initial begin
        rst_n = 1'b1;
        req   = 8'd0;
        ack   = 1'b0;

        // 1: lines high through reset count as edges on release.
        #1 rst_n = 1'b0;
        req = 8'hFF;
        repeat (3) @(negedge clk);
        check("t1 reset valid", 8'(d_valid[0]), 8'h00);
        check("t1 reset pending", d_pend[0], 8'h00);
        check("t1 reset vector", 8'(d_vec[0]), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1 pending after 1st edge", d_pend[0], 8'hFF);
        check("t1 valid after 1st edge", 8'(d_valid[0]), 8'h00);
        @(negedge clk);
        check("t1 valid after 2nd edge", 8'(d_valid[0]), 8'h01);
        check("t1 hi code", 8'(d_vec[0]), 8'h07);
        check("t1 lo code", 8'(d_vec[1]), 8'h00);
        // Hold ack high to drain all eight.
        ack = 1'b1;
        req = 8'd0;
        repeat (20) @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        check("t1 drained hi", d_pend[0], 8'h00);
        check("t1 drained lo", d_pend[1], 8'h00);
        check("t1 drained valid", 8'(d_valid[0]), 8'h00);

        // 2: single request, two-cycle latency.
        req = 8'h08;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("t2 valid", 8'(d_valid[0]), 8'h01);
        check("t2 code", 8'(d_vec[0]), 8'h03);
        check("t2 pending", d_pend[0], 8'h08);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t2 valid after ack", 8'(d_valid[0]), 8'h00);
        check("t2 pending after ack", d_pend[0], 8'h00);

        // 3: simultaneous requests, order depends on priority direction.
        req = 8'h24;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("t3 hi first", 8'(d_vec[0]), 8'h05);
        check("t3 lo first", 8'(d_vec[1]), 8'h02);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t3 gap valid hi", 8'(d_valid[0]), 8'h00);
        check("t3 gap valid lo", 8'(d_valid[1]), 8'h00);
        @(negedge clk);
        check("t3 hi second", 8'(d_vec[0]), 8'h02);
        check("t3 lo second", 8'(d_vec[1]), 8'h05);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t3 pending empty", d_pend[0], 8'h00);

        // 4: higher-priority edge during PRESENT does not disturb the code.
        req = 8'h04;
        @(negedge clk);
        @(negedge clk);
        check("t4 code 010", 8'(d_vec[0]), 8'h02);
        req = 8'h44;
        @(negedge clk);
        check("t4 code frozen", 8'(d_vec[0]), 8'h02);
        check("t4 pending 44", d_pend[0], 8'h44);
        req = 8'h00;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        check("t4 code 110", 8'(d_vec[0]), 8'h06);
        check("t4 valid", 8'(d_valid[0]), 8'h01);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // 5: repeated edge is merged and flagged; set wins over clear.
        req = 8'h02;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("t5 code 001", 8'(d_vec[0]), 8'h01);
        req = 8'h02;
        @(negedge clk);
        check("t5 lost pulse", 8'(d_lost[0]), 8'h01);
        check("t5 pending 02", d_pend[0], 8'h02);
        req = 8'h00;
        @(negedge clk);
        check("t5 lost one cycle", 8'(d_lost[0]), 8'h00);
        req = 8'h02;
        ack = 1'b1;
        @(negedge clk);
        req = 8'h00;
        ack = 1'b0;
        check("t5 set wins", d_pend[0], 8'h02);
        check("t5 no lost on clear", 8'(d_lost[0]), 8'h00);
        @(negedge clk);
        check("t5 re-presented", 8'(d_vec[0]), 8'h01);
        check("t5 re-valid", 8'(d_valid[0]), 8'h01);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // 6: asynchronous reset while presenting.
        req = 8'hA0;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("t6 hi code 111", 8'(d_vec[0]), 8'h07);
        check("t6 lo code 101", 8'(d_vec[1]), 8'h05);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("t6[%0d] async valid", m), 8'(d_valid[m]), 8'h00);
            check($sformatf("t6[%0d] async pending", m), d_pend[m], 8'h00);
            check($sformatf("t6[%0d] async vector", m), 8'(d_vec[m]), 8'h00);
            check($sformatf("t6[%0d] async lost", m), 8'(d_lost[m]), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
